// File: rtl/encoder_code_fifo.sv
// encoder_code_fifo: FWFT queue for encoder codes with occupancy and overflow pulse (optional drop counter via ENC_FIFO_DROP_CNT_EN)
module encoder_code_fifo #(
    parameter int CODE_W = 2,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic              valid_in,
    output logic [CODE_W-1:0] code_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              drop
`ifdef ENC_FIFO_DROP_CNT_EN
    ,
    input  logic              drop_clr,
    output logic [7:0]        drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic pop, push, rej;
    assign full = count == CNT_W'(DEPTH);
    assign empty = count == '0;
    assign out_valid = ~empty;
    assign pop = out_valid & out_ready;
    assign push = valid_in & (~full | pop);
    assign rej = valid_in & full & ~pop;
    assign code_out = out_valid ? mem[rd_ptr] : '0;
    // storage write; contents are don't-care until pushed, so no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= code_in;
    end
    // pointers, occupancy and the registered overflow pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            drop <= 1'b0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            drop <= rej;
        end
    end
`ifdef ENC_FIFO_DROP_CNT_EN
    // saturating count of rejected pushes; clear beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt <= '0;
        else drop_cnt <= drop_clr ? 8'd0 : (rej && drop_cnt != 8'hff) ? drop_cnt + 8'd1 : drop_cnt;
    end
`endif
endmodule
